// File: rtl/uart_tx.sv
// uart_tx: serialises one byte into an 11-bit frame on a registered tx line.
// Frame order: start(0), data bits 0..7, parity, stop(1). Each bit lasts
// BAUD_DIV clock cycles, timed by an internal bit-period counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line high, waiting for tx_start
// S_START  | start bit (0) on the line
// S_DATA   | data bits, LSB first; idx_q tracks which bit is on the line
// S_PARITY | parity bit on the line
// S_STOP   | stop bit (1) on the line; tx_done fires when it ends
module uart_tx #(
    parameter int BAUD_DIV   = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       baud_tick
);

    localparam int            CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick;

    // Last cycle of the current bit period; never asserted while idle.
    assign tick = (state_q != S_IDLE) && (cnt_q == CNT_LAST);

    // Next-state logic: bit counter, frame sequencing and line value.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if ((state_q == S_IDLE) || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                idx_d = 3'd0;
                tx_d  = 1'b1;
                if (tx_start) begin
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ ODD;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        tx_d    = par_q;
                        state_d = S_PARITY;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any partial frame and parks the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx        = tx_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;
    assign baud_tick = tick;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with BAUD_DIV = 4: one even-parity and one
// odd-parity instance share the stimulus. A small sampling receiver on the
// even instance's line checks loopback decoding.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_e, busy_e, done_e, tick_e;
    logic       tx_o, busy_o, done_o, tick_o;

    int checks = 0;
    int errors = 0;

    uart_tx #(.BAUD_DIV(4), .PARITY_ODD(0)) dut_even (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .tx(tx_e), .tx_busy(busy_e), .tx_done(done_e), .baud_tick(tick_e)
    );

    uart_tx #(.BAUD_DIV(4), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .tx(tx_o), .tx_busy(busy_o), .tx_done(done_o), .baud_tick(tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sampling receiver: detect start edge, sample each bit mid-period.
    logic       rx_act = 1'b0;
    int         rx_off = 0;
    logic [9:1] rx_bits = '0;
    logic [7:0] rx_d_out = 8'd0;
    logic       rx_p_error = 1'b0;
    logic       rx_stop_error = 1'b0;
    int         rx_frames = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_act <= 1'b0;
            rx_off <= 0;
        end else if (!rx_act) begin
            if (!tx_e) begin
                rx_act <= 1'b1;
                rx_off <= 2;
            end
        end else begin
            rx_off <= rx_off + 1;
            if (rx_off == 42) begin
                rx_act        <= 1'b0;
                rx_d_out      <= rx_bits[8:1];
                rx_p_error    <= ^rx_bits[9:1];
                rx_stop_error <= ~tx_e;
                rx_frames     <= rx_frames + 1;
            end else if ((rx_off % 4 == 2) && (rx_off >= 6)) begin
                rx_bits[rx_off / 4] <= tx_e;
            end
        end
    end

    function automatic logic [43:0] expand(input logic [10:0] f);
        logic [43:0] r;
        for (int j = 0; j < 44; j++) r[j] = f[j / 4];
        return r;
    endfunction

    task automatic start_frame(input logic [7:0] d);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = d;
        @(posedge clk);
    endtask

    // Called at the accepting edge E; records both lines for 44 cycles,
    // then samples status just after edge E+44.
    task automatic capture(input int pulse_at, input logic keep_start, input logic [7:0] mid_data,
                           output logic [43:0] se, output logic [43:0] so,
                           output int ticks_e, output int ticks_o, output int done_mid,
                           output int busy_gaps, output logic done_end,
                           output logic busy_end, output logic tx_end);
        se = '0; so = '0; ticks_e = 0; ticks_o = 0; done_mid = 0; busy_gaps = 0;
        for (int j = 0; j < 44; j++) begin
            #1;
            se[j] = tx_e;
            so[j] = tx_o;
            if (tick_e) ticks_e++;
            if (tick_o) ticks_o++;
            if (done_e || done_o) done_mid++;
            if (!busy_e || !busy_o) busy_gaps++;
            if (j == 0 && !keep_start) tx_start = 1'b0;
            if (j == 5) tx_data = mid_data;
            if (pulse_at > 0 && j == pulse_at - 1) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end
            if (pulse_at > 0 && j == pulse_at) tx_start = 1'b0;
            @(posedge clk);
        end
        #1;
        done_end = done_e & done_o;
        busy_end = busy_e | busy_o;
        tx_end   = tx_e & tx_o;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tx_start = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            checks++;
            if ({tx_e, busy_e, done_e, tick_e, tx_o, busy_o, done_o, tick_o} !== 8'b1000_1000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b required 10001000", i,
                         {tx_e, busy_e, done_e, tick_e, tx_o, busy_o, done_o, tick_o});
            end
        end
        @(negedge clk);
        tx_start = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_even_frame();
        logic [43:0] se, so;
        int te, to, dm, bg;
        logic de, be, xe;
        start_frame(8'hA5);
        capture(-1, 1'b0, 8'h00, se, so, te, to, dm, bg, de, be, xe);
        checks++;
        if (se !== expand(11'b10101001010)) begin
            errors++; $display("FAIL even_A5_line: got %h required %h", se, expand(11'b10101001010));
        end
        checks++;
        if (so !== expand(11'b11101001010)) begin
            errors++; $display("FAIL odd_A5_line: got %h required %h", so, expand(11'b11101001010));
        end
        checks++;
        if (te !== 11 || to !== 11) begin
            errors++; $display("FAIL A5_ticks: got %0d/%0d required 11", te, to);
        end
        checks++;
        if (dm !== 0 || bg !== 0) begin
            errors++; $display("FAIL A5_inframe: done %0d busy_gaps %0d required 0", dm, bg);
        end
        checks++;
        if ({de, be, xe} !== 3'b101) begin
            errors++; $display("FAIL A5_end_E44: done,busy,tx=%b required 101", {de, be, xe});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done_e, tick_e, busy_e, tx_e} !== 4'b0001) begin
            errors++; $display("FAIL A5_after_done: done,tick,busy,tx=%b required 0001",
                               {done_e, tick_e, busy_e, tx_e});
        end
    endtask

    task automatic test_odd_parity();
        logic [43:0] se, so;
        int te, to, dm, bg;
        logic de, be, xe;
        start_frame(8'h55);
        capture(-1, 1'b0, 8'h00, se, so, te, to, dm, bg, de, be, xe);
        checks++;
        if (so !== expand(11'b11010101010)) begin
            errors++; $display("FAIL odd_55_line: got %h required %h", so, expand(11'b11010101010));
        end
        checks++;
        if (se !== expand(11'b10010101010)) begin
            errors++; $display("FAIL even_55_line: got %h required %h", se, expand(11'b10010101010));
        end
        start_frame(8'h00);
        capture(-1, 1'b0, 8'h00, se, so, te, to, dm, bg, de, be, xe);
        checks++;
        if (so !== expand(11'b11000000000)) begin
            errors++; $display("FAIL odd_00_line: got %h required %h", so, expand(11'b11000000000));
        end
        checks++;
        if (se !== expand(11'b10000000000)) begin
            errors++; $display("FAIL even_00_line: got %h required %h", se, expand(11'b10000000000));
        end
    endtask

    task automatic test_busy_ignore();
        logic [43:0] se, so;
        int te, to, dm, bg, extra;
        logic de, be, xe;
        start_frame(8'h3C);
        capture(8, 1'b0, 8'hC3, se, so, te, to, dm, bg, de, be, xe);
        checks++;
        if (se !== expand(11'b10001111000)) begin
            errors++; $display("FAIL busy_3C_even: got %h required %h", se, expand(11'b10001111000));
        end
        checks++;
        if (so !== expand(11'b11001111000)) begin
            errors++; $display("FAIL busy_3C_odd: got %h required %h", so, expand(11'b11001111000));
        end
        checks++;
        if ({de, be, dm} !== {1'b1, 1'b0, 32'd0}) begin
            errors++; $display("FAIL busy_3C_done: end %b busy %b mid %0d required 1 0 0", de, be, dm);
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (busy_e || busy_o || done_e || done_o || !tx_e || !tx_o) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL busy_no_second_frame: got %0d active cycles required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [43:0] se, so;
        int te, to, dm, bg;
        logic de, be, xe;
        start_frame(8'h12);
        capture(-1, 1'b1, 8'h34, se, so, te, to, dm, bg, de, be, xe);
        checks++;
        if (se !== expand(11'b10000100100) || so !== expand(11'b11000100100)) begin
            errors++; $display("FAIL b2b_first_12: got %h/%h required %h/%h", se, so,
                               expand(11'b10000100100), expand(11'b11000100100));
        end
        checks++;
        if ({de, be, xe} !== 3'b101) begin
            errors++; $display("FAIL b2b_gap_cycle: done,busy,tx=%b required 101", {de, be, xe});
        end
        @(posedge clk);
        capture(-1, 1'b0, 8'h34, se, so, te, to, dm, bg, de, be, xe);
        checks++;
        if (se !== expand(11'b11001101000) || so !== expand(11'b10001101000)) begin
            errors++; $display("FAIL b2b_second_34: got %h/%h required %h/%h", se, so,
                               expand(11'b11001101000), expand(11'b10001101000));
        end
        checks++;
        if ({de, be, xe} !== 3'b101) begin
            errors++; $display("FAIL b2b_second_end: done,busy,tx=%b required 101", {de, be, xe});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [43:0] se, so;
        int te, to, dm, bg, stray, frames0;
        logic de, be, xe;
        start_frame(8'h3C);
        #1;
        tx_start = 1'b0;
        repeat (17) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({tx_e, busy_e, done_e, tick_e, tx_o, busy_o, done_o, tick_o} !== 8'b1000_1000) begin
            errors++; $display("FAIL reset_mid_frame: got %b required 10001000",
                               {tx_e, busy_e, done_e, tick_e, tx_o, busy_o, done_o, tick_o});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!tx_e || busy_e || tick_e || done_e) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL reset_no_resume: got %0d active cycles required 0", stray);
        end
        frames0 = rx_frames;
        start_frame(8'h81);
        capture(-1, 1'b0, 8'h00, se, so, te, to, dm, bg, de, be, xe);
        checks++;
        if (se !== expand(11'b10100000010) || so !== expand(11'b11100000010)) begin
            errors++; $display("FAIL post_reset_81: got %h/%h required %h/%h", se, so,
                               expand(11'b10100000010), expand(11'b11100000010));
        end
        checks++;
        if (rx_frames !== frames0 + 1 || rx_d_out !== 8'h81) begin
            errors++; $display("FAIL loopback_81: frames %0d data %h required %0d 81",
                               rx_frames - frames0, rx_d_out, 1);
        end
        checks++;
        if (rx_p_error !== 1'b0 || rx_stop_error !== 1'b0) begin
            errors++; $display("FAIL loopback_errors: p_error %b stop_error %b required 0 0",
                               rx_p_error, rx_stop_error);
        end
    endtask

    initial begin
        tx_start = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_even_frame();
        test_odd_parity();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
